// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache in front of a burst RAM.
// A line is filled or drained as one burst; hits answer on the following cycle.
module data_cache #(
    parameter int unsigned LINE_IX_BITWIDTH         = 1,
    parameter int unsigned WORD_IX_IN_LINE_BITWIDTH = 3,
    parameter int unsigned RAM_DEPTH_BITWIDTH       = 4,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int unsigned RAM_BURST_DATA_COUNT     = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                enable,
    input  logic [RAM_DEPTH_BITWIDTH+WORD_IX_IN_LINE_BITWIDTH-1:0] address,
    input  logic [3:0]                                          write_enable,
    input  logic [31:0]                                         data_in,
    output logic [31:0]                                         data_out,
    output logic                                                data_ready,
    output logic                                                busy,
    output logic                                                br_cmd,
    output logic                                                br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]                       br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]                  br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]                br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]                  br_rd_data,
    input  logic                                                br_rd_data_valid,
    input  logic                                                br_busy
);
    localparam int unsigned AddrW = RAM_DEPTH_BITWIDTH + WORD_IX_IN_LINE_BITWIDTH;
    localparam int unsigned TagW  = RAM_DEPTH_BITWIDTH - LINE_IX_BITWIDTH;
    localparam int unsigned Lines = 1 << LINE_IX_BITWIDTH;
    localparam int unsigned LineW = 32 << WORD_IX_IN_LINE_BITWIDTH;
    localparam int unsigned BeatW = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [2:0] {
        StIdle, StWbIssue, StWbData, StFillIssue, StFillData, StRespond
    } state_e;

    state_e                      state_q, state_d;
    logic [BeatW-1:0]            beat_q, beat_d, beat_next;
    logic [Lines-1:0]            valid_q, valid_d, dirty_q, dirty_d;
    logic [Lines-1:0][TagW-1:0]  tag_q, tag_d;
    logic [Lines-1:0][LineW-1:0] line_q, line_d;
    logic [AddrW-1:0]            req_addr_q, req_addr_d;
    logic [3:0]                  req_we_q, req_we_d;
    logic [31:0]                 req_wdata_q, req_wdata_d;
    logic [31:0]                 data_out_q, data_out_d;
    logic                        data_ready_q, data_ready_d;
    logic [31:0]                 merged;

    logic [WORD_IX_IN_LINE_BITWIDTH-1:0] in_word, req_word;
    logic [LINE_IX_BITWIDTH-1:0]         in_line, req_line;
    logic [TagW-1:0]                     in_tag, req_tag;
    logic                                in_hit;

    assign in_word  = address[WORD_IX_IN_LINE_BITWIDTH-1:0];
    assign in_line  = address[WORD_IX_IN_LINE_BITWIDTH +: LINE_IX_BITWIDTH];
    assign in_tag   = address[AddrW-1 -: TagW];
    assign req_word = req_addr_q[WORD_IX_IN_LINE_BITWIDTH-1:0];
    assign req_line = req_addr_q[WORD_IX_IN_LINE_BITWIDTH +: LINE_IX_BITWIDTH];
    assign req_tag  = req_addr_q[AddrW-1 -: TagW];

    assign in_hit    = valid_q[in_line] && (tag_q[in_line] == in_tag);
    assign beat_next = (beat_q == LastBeat) ? '0 : beat_q + 1'b1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [3:0] be,
                                                input logic [31:0] din);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? din[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign busy         = (state_q != StIdle);
    assign data_out     = data_out_q;
    assign data_ready   = data_ready_q;
    assign br_data_mask = '0;
    // Victim address during write-back, requested address otherwise.
    assign br_addr = (state_q == StWbIssue || state_q == StWbData) ?
                     {tag_q[req_line], req_line} : {req_tag, req_line};
    // beat_q rests at 0 outside bursts, so WB_ISSUE presents beat 0.
    assign br_wr_data = line_q[req_line][beat_q*RAM_BURST_DATA_BITWIDTH +: RAM_BURST_DATA_BITWIDTH];

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        line_d       = line_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        req_wdata_d  = req_wdata_q;
        data_out_d   = data_out_q;
        data_ready_d = 1'b0;
        merged       = '0;
        br_cmd       = 1'b0;
        br_cmd_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    req_addr_d  = address;
                    req_we_d    = write_enable;
                    req_wdata_d = data_in;
                    if (in_hit) begin
                        merged       = merge_bytes(line_q[in_line][in_word*32 +: 32],
                                                   write_enable, data_in);
                        data_ready_d = 1'b1;
                        data_out_d   = merged;
                        if (write_enable != 4'b0000) begin
                            line_d[in_line][in_word*32 +: 32] = merged;
                            dirty_d[in_line]                  = 1'b1;
                        end
                    end else if (valid_q[in_line] && dirty_q[in_line]) begin
                        state_d = StWbIssue;
                    end else begin
                        state_d = StFillIssue;
                    end
                end
            end
            StWbIssue: begin
                br_cmd = 1'b1;
                if (!br_busy) begin
                    br_cmd_en = 1'b1;
                    beat_d    = beat_next;
                    state_d   = (beat_q == LastBeat) ? StFillIssue : StWbData;
                end
            end
            StWbData: begin
                br_cmd = 1'b1;
                beat_d = beat_next;
                if (beat_q == LastBeat) state_d = StFillIssue;
            end
            StFillIssue: begin
                if (!br_busy) begin
                    br_cmd_en = 1'b1;
                    state_d   = StFillData;
                end
            end
            StFillData: begin
                if (br_rd_data_valid) begin
                    line_d[req_line][beat_q*RAM_BURST_DATA_BITWIDTH +: RAM_BURST_DATA_BITWIDTH] =
                        br_rd_data;
                    beat_d = beat_next;
                    if (beat_q == LastBeat) state_d = StRespond;
                end
            end
            StRespond: begin
                merged              = merge_bytes(line_q[req_line][req_word*32 +: 32],
                                                  req_we_q, req_wdata_q);
                tag_d[req_line]     = req_tag;
                valid_d[req_line]   = 1'b1;
                dirty_d[req_line]   = (req_we_q != 4'b0000);
                line_d[req_line][req_word*32 +: 32] = merged;
                data_ready_d        = 1'b1;
                data_out_d          = merged;
                state_d             = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            data_ready_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            data_ready_q <= data_ready_d;
            data_out_q   <= data_out_d;
        end
    end

    // Payload storage needs no reset: lines are guarded by valid_q.
    always_ff @(posedge clk) begin
        tag_q       <= tag_d;
        line_q      <= line_d;
        req_addr_q  <= req_addr_d;
        req_we_q    <= req_we_d;
        req_wdata_q <= req_wdata_d;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter LINE_IX_BITWIDTH, default 1, meaning 2^N direct-mapped cache lines.
REQ-002 SHALL have parameter WORD_IX_IN_LINE_BITWIDTH, default 3, meaning 2^N 32-bit words per line.
REQ-003 SHALL have parameter RAM_DEPTH_BITWIDTH, default 4, meaning BurstRAM line-address width; word address width = RAM_DEPTH_BITWIDTH + WORD_IX_IN_LINE_BITWIDTH.
REQ-004 SHALL have parameter RAM_BURST_DATA_BITWIDTH, default 64, meaning bits per burst beat (multiple of 32).
REQ-005 SHALL have parameter RAM_BURST_DATA_COUNT, default 4, meaning beats per burst; COUNT*BURST_BITWIDTH SHALL equal 32*2^WORD_IX_IN_LINE_BITWIDTH (one burst = one line).
REQ-006 SHALL have ports: clk in 1, system clock; rst in 1, reset.
REQ-007 SHALL have ports: enable in 1, request strobe; address in RAM_DEPTH_BITWIDTH+WORD_IX_IN_LINE_BITWIDTH, word address; write_enable in 4, byte enables (0000 = read); data_in in 32; data_out out 32; data_ready out 1; busy out 1.
REQ-008 SHALL have BurstRAM ports: br_cmd out 1 (0 read, 1 write); br_cmd_en out 1; br_addr out RAM_DEPTH_BITWIDTH; br_wr_data out RAM_BURST_DATA_BITWIDTH; br_data_mask out RAM_BURST_DATA_BITWIDTH/8 (1 = byte masked); br_rd_data in RAM_BURST_DATA_BITWIDTH; br_rd_data_valid in 1; br_busy in 1.
REQ-009 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-010 Address split SHALL be word = address[WORD_IX-1:0], line = next LINE_IX bits, tag = remaining upper bits; br_addr for a line = {tag, line}.
REQ-011 Word w of a line SHALL map to beat w/(BURST_BITWIDTH/32), bit offset (w mod (BURST_BITWIDTH/32))*32.
REQ-012 Each line SHALL hold tag, valid bit, dirty bit, data; policy write-back, write-allocate.
REQ-013 Request SHALL be accepted on a cycle with enable=1 and busy=0; enable while busy=1 SHALL be ignored.
REQ-014 FSM states SHALL be IDLE, WB_ISSUE, WB_DATA, FILL_ISSUE, FILL_DATA, RESPOND.
REQ-015 Hit (valid and tag match), accepted cycle T: data_ready=1 for exactly cycle T+1, data_out = stored word (read) or merged word (write); busy stays 0; no br_cmd_en.
REQ-016 Write hit SHALL update only bytes with write_enable[i]=1 and set dirty.
REQ-017 Miss: busy=1 from T+1 until the data_ready cycle inclusive-exclusive (busy falls the cycle data_ready rises); request fields latched at T.
REQ-018 Miss on valid dirty line: IDLE->WB_ISSUE; when br_busy=0, br_cmd=1, br_cmd_en=1 one cycle, br_addr = {old tag, line}, beat 0 on br_wr_data, mask all 0; WB_DATA drives beats 1..COUNT-1 on consecutive cycles; then FILL_ISSUE.
REQ-019 Miss on clean or invalid line: IDLE->FILL_ISSUE directly.
REQ-020 FILL_ISSUE: when br_busy=0, br_cmd=0, br_cmd_en=1 one cycle, br_addr = {new tag, line}; FILL_DATA stores one beat per br_rd_data_valid cycle, beat counter wraps to 0 after COUNT-1.
REQ-021 After last beat -> RESPOND: set tag, valid=1, dirty=0, apply pending write (then dirty=1), data_ready=1 one cycle with data_out as in REQ-015, -> IDLE.
REQ-022 br_cmd_en SHALL be 0 in all states except the single issue cycle; br_data_mask SHALL be 0 always.
REQ-023 data_out SHALL hold its value when data_ready=0.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, all valid and dirty bits 0, beat counter 0, data_ready=0, busy=0, br_cmd_en=0, br_cmd=0, data_out=0.
REQ-025 Reset mid-burst SHALL abort without writing back; line contents after reset undefined but invalid.

Verification (defaults: 2 lines, 8 words/line, 7-bit address)
REQ-026 After reset, read 0x00, RAM line 0 beat0=0x0000_0002_1122_3344 -> one read cmd br_addr=0, 4 beats, data_ready once, data_out=0x11223344, no write cmd.
REQ-027 Then read 0x01 -> data_ready next cycle, data_out=0x00000002, busy stays 0, no br_cmd_en.
REQ-028 Write 0x00 write_enable=0011 data_in=0xAABBCCDD, then read 0x00 -> data_out=0x1122CCDD, no RAM traffic.
REQ-029 Read 0x10 (line 0, tag 1) -> write cmd br_addr=0 with beat0 low word 0x1122CCDD, then read cmd br_addr=2, data_ready with RAM word.
REQ-030 enable pulsed during busy -> ignored (one data_ready total); rst asserted in FILL_DATA -> busy=0 next cycle, re-read 0x00 misses and issues read cmd br_addr=0.
